pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Drives the en and synchronous-clear inputs of the five pipeline stage registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Detects load-use hazards and taken branches, and sequences multi-cycle EX operations via a start/done handshake.
//  Sits in the top-level CPU beside the datapath. Every stage register's en/clear pin connects to an output here.
// PARAMETERS
//  REG_AW      5    register address width (rs1/rs2/rd)
//  MC_TIMEOUT  64   max MC_WAIT cycles before entering MC_ERR; legal range 2..255
//  CNT_W       32   width of the stall statistics counters
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous, active-high reset
//  id_rs1       in   REG_AW source reg 1 of the instruction in ID
//  id_rs2       in   REG_AW source reg 2 of the instruction in ID
//  ex_rd        in   REG_AW destination reg of the instruction in EX
//  ex_memread   in   1      instruction in EX is a load
//  ex_br_taken  in   1      branch resolved taken in EX
//  mc_start     in   1      instruction in EX needs the multi-cycle unit
//  mc_done      in   1      multi-cycle unit result valid this cycle
//  pc_en, ifid_en, idex_en, exmem_en, memwb_en   out 1  stage register enables
//  ifid_clr, idex_clr, exmem_clr                 out 1  stage register synchronous clears (bubble insert)
//  stall        out  1      any stage frozen this cycle
//  mc_err       out  1      sticky multi-cycle timeout flag
//  stall_cnt    out  CNT_W  stall cycles (see CONFIGURATION)
//  flush_cnt    out  CNT_W  taken-branch flushes (see CONFIGURATION)
// BEHAVIOUR
//  - FSM states: RUN, MC_WAIT, MC_ERR. State and wait counter are registered; outputs decode combinationally from state and inputs.
//  - rst high (async): state=RUN, wait counter=0, mc_err=0, counters=0.
//    While rst is high, outputs are forced to: all *_en=0, all *_clr=1, stall=0.
//  - Default outputs in RUN: all *_en=1, all *_clr=0, stall=0.
//  - RUN priority (highest first):
//    1) ex_br_taken: ifid_clr=1, idex_clr=1; all enables stay 1; state stays RUN.
//    2) mc_start && !mc_done: pc_en=ifid_en=idex_en=0, exmem_clr=1, stall=1; next state MC_WAIT; counter<=1.
//       mc_start && mc_done in the same cycle: treated as single-cycle; no stall.
//    3) load-use: ex_memread && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
//       Response: pc_en=ifid_en=0, idex_clr=1, stall=1; exactly one bubble; state stays RUN.
//  - MC_WAIT:
//    - mc_done=1: all enables 1, no clears; next state RUN; counter<=0.
//    - Otherwise: same outputs as the mc_start stall; counter increments.
//      When counter==MC_TIMEOUT, next state is MC_ERR.
//    - ex_br_taken and load-use are ignored in MC_WAIT (EX is frozen).
//  - MC_ERR: all *_en=0, stall=1, mc_err=1. The only exit is rst.
//  - ex_rd==0 never creates a hazard. Counters saturate at all-ones; they never wrap.
// CONFIGURATION
//  PIPE_STALL_STATS_EN defined:
//    - stall_cnt increments each cycle stall=1.
//    - flush_cnt increments each cycle rule 1 fires.
//  Not defined: stall_cnt and flush_cnt tied to 0, no counter flops. The port list is unchanged.
// STRUCTURE
//  - pipe_ctrl_pkg: state enum {RUN, MC_WAIT, MC_ERR} (2-bit encoding 00/01/10) and the REG_AW default constant.
//  - One sub-module, sat_counter (CNT_W, inc, clr), instantiated twice under PIPE_STALL_STATS_EN.
//  - FSM and hazard compare stay in this module.
// TESTING
//  1) Reset mid-MC_WAIT: pulse rst for 1 cycle -> enables 0 and clears 1 during rst; next cycle state RUN, all en=1.
//  2) Load-use: ex_memread=1, ex_rd=5, id_rs2=5 for 1 cycle -> pc_en=ifid_en=0, idex_clr=1, stall=1 that cycle only.
//     Repeat with ex_rd=0 -> no stall.
//  3) Branch collision: ex_br_taken=1 together with a load-use match -> ifid_clr=idex_clr=1, pc_en=1, stall=0.
//  4) Multi-cycle: mc_start=1, mc_done rises 3 cycles later -> stall=1 for 3 cycles.
//     On the done cycle all en=1; back in RUN.
//  5) Timeout: MC_TIMEOUT=4, mc_start with no mc_done -> mc_err=1 after 4 wait cycles; stays set until rst.
//  6) Stats (macro on): 2 load-use stalls + 1 flush -> stall_cnt=2, flush_cnt=1.
//     Macro off: both read 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// FSM state encoding, default register-address width and wait-counter width.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StMcWait = 2'b01,
        StMcErr  = 2'b10
    } state_e;

    localparam int unsigned REG_AW_DEFAULT = 5;

    // Wide enough for the largest legal MC_TIMEOUT (255).
    localparam int unsigned WAIT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stage-register enable/clear controller: branch flush, load-use bubble and
// multi-cycle EX sequencing. Define PIPE_STALL_STATS_EN to build the stall/flush counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW     = REG_AW_DEFAULT,
    parameter int unsigned MC_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic              ex_br_taken,
    input  logic              mc_start,
    input  logic              mc_done,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_clr,
    output logic              idex_clr,
    output logic              exmem_clr,
    output logic              stall,
    output logic              mc_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [WAIT_W-1:0] TimeoutVal = WAIT_W'(MC_TIMEOUT);

    state_e            state_q;
    state_e            state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic              load_use;
    logic              flush;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_comb begin
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        idex_en   = 1'b1;
        exmem_en  = 1'b1;
        memwb_en  = 1'b1;
        ifid_clr  = 1'b0;
        idex_clr  = 1'b0;
        exmem_clr = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        state_d   = state_q;
        wait_d    = wait_q;

        if (rst) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            memwb_en  = 1'b0;
            ifid_clr  = 1'b1;
            idex_clr  = 1'b1;
            exmem_clr = 1'b1;
        end else begin
            case (state_q)
                StRun: begin
                    if (ex_br_taken) begin
                        ifid_clr = 1'b1;
                        idex_clr = 1'b1;
                        flush    = 1'b1;
                    end else if (mc_start && !mc_done) begin
                        pc_en     = 1'b0;
                        ifid_en   = 1'b0;
                        idex_en   = 1'b0;
                        exmem_clr = 1'b1;
                        stall     = 1'b1;
                        state_d   = StMcWait;
                        wait_d    = WAIT_W'(1);
                    end else if (load_use) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_clr = 1'b1;
                        stall    = 1'b1;
                    end
                end
                StMcWait: begin
                    if (mc_done) begin
                        state_d = StRun;
                        wait_d  = '0;
                    end else begin
                        // EX is frozen here, so branch and load-use inputs are stale.
                        pc_en     = 1'b0;
                        ifid_en   = 1'b0;
                        idex_en   = 1'b0;
                        exmem_clr = 1'b1;
                        stall     = 1'b1;
                        wait_d    = wait_q + 1'b1;
                        if (wait_q == TimeoutVal) begin
                            state_d = StMcErr;
                        end
                    end
                end
                StMcErr: begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                    stall    = 1'b1;
                end
                default: begin
                    state_d = StRun;
                    wait_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign mc_err = (state_q == StMcErr);

`ifdef PIPE_STALL_STATS_EN
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall),
        .clr   (1'b0),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .clr   (1'b0),
        .count (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MC_TIMEOUT=4).
// Output vector order: pc,ifid,idex,exmem,memwb en | ifid,idex,exmem clr | stall | mc_err.
module tb_pipe_hazard_ctrl;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 32;

    localparam logic [9:0] V_NORM = 10'b11111_000_00;
    localparam logic [9:0] V_RST  = 10'b00000_111_00;
    localparam logic [9:0] V_BR   = 10'b11111_110_00;
    localparam logic [9:0] V_LU   = 10'b00111_010_10;
    localparam logic [9:0] V_MC   = 10'b00011_001_10;
    localparam logic [9:0] V_ERR  = 10'b00000_000_11;

`ifdef PIPE_STALL_STATS_EN
    localparam logic [31:0] EXP_STALLS  = 32'd2;
    localparam logic [31:0] EXP_FLUSHES = 32'd1;
`else
    localparam logic [31:0] EXP_STALLS  = 32'd0;
    localparam logic [31:0] EXP_FLUSHES = 32'd0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
    logic              ex_memread, ex_br_taken, mc_start, mc_done;
    logic              pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic              ifid_clr, idex_clr, exmem_clr, stall, mc_err;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
    logic [9:0]        outv;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_AW     (REG_AW),
        .MC_TIMEOUT (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_rd       (ex_rd),
        .ex_memread  (ex_memread),
        .ex_br_taken (ex_br_taken),
        .mc_start    (mc_start),
        .mc_done     (mc_done),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .ifid_clr    (ifid_clr),
        .idex_clr    (idex_clr),
        .exmem_clr   (exmem_clr),
        .stall       (stall),
        .mc_err      (mc_err),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    assign outv = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_clr, idex_clr, exmem_clr, stall, mc_err};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check before the next rising edge.
    task automatic step(input string tag, input logic br, input logic mrd,
                        input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs1,
                        input logic [REG_AW-1:0] rs2, input logic mcs, input logic mcd,
                        input logic [9:0] exp);
        @(negedge clk);
        ex_br_taken = br;
        ex_memread  = mrd;
        ex_rd       = rd;
        id_rs1      = rs1;
        id_rs2      = rs2;
        mc_start    = mcs;
        mc_done     = mcd;
        #2;
        check(tag, 32'(outv), 32'(exp));
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        {ex_br_taken, ex_memread, mc_start, mc_done} = '0;
        {ex_rd, id_rs1, id_rs2} = '0;
        #2;
        check(tag, 32'(outv), 32'(V_RST));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {ex_br_taken, ex_memread, mc_start, mc_done} = '0;
        {ex_rd, id_rs1, id_rs2} = '0;
        #2;
        check("reset_outputs", 32'(outv), 32'(V_RST));
        check("reset_stall_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step("run_idle", 0, 0, 0, 0, 0, 0, 0, V_NORM);

        // Reset while waiting on the multi-cycle unit.
        step("mc_enter", 0, 0, 0, 0, 0, 1, 0, V_MC);
        step("mc_wait", 0, 0, 0, 0, 0, 1, 0, V_MC);
        pulse_reset("rst_mid_wait");
        step("after_rst_run", 0, 0, 0, 0, 0, 0, 0, V_NORM);

        // Load-use hazards.
        step("lu_rs2", 0, 1, 5, 0, 5, 0, 0, V_LU);
        step("lu_one_bubble", 0, 0, 5, 0, 5, 0, 0, V_NORM);
        step("lu_rs1", 0, 1, 7, 7, 3, 0, 0, V_LU);
        step("lu_rd_zero", 0, 1, 0, 0, 0, 0, 0, V_NORM);
        step("lu_no_match", 0, 1, 6, 1, 2, 0, 0, V_NORM);
        step("no_load_match", 0, 0, 5, 5, 5, 0, 0, V_NORM);

        // Branch beats load-use and mc_start.
        step("br_vs_lu", 1, 1, 5, 0, 5, 0, 0, V_BR);
        step("br_vs_mc", 1, 0, 0, 0, 0, 1, 0, V_BR);
        step("mc_same_cycle_done", 0, 0, 0, 0, 0, 1, 1, V_NORM);

        // Multi-cycle op finishing three cycles after start.
        step("mc_c0", 0, 0, 0, 0, 0, 1, 0, V_MC);
        step("mc_c1_br_ignored", 1, 1, 5, 5, 0, 1, 0, V_MC);
        step("mc_c2", 0, 0, 0, 0, 0, 1, 0, V_MC);
        step("mc_done_cycle", 0, 0, 0, 0, 0, 1, 1, V_NORM);
        step("mc_back_run", 0, 1, 5, 5, 0, 0, 0, V_LU);

        // Timeout: four wait cycles then sticky error.
        step("to_start", 0, 0, 0, 0, 0, 1, 0, V_MC);
        for (int i = 1; i <= 4; i++) begin
            step($sformatf("to_wait%0d", i), 0, 0, 0, 0, 0, 1, 0, V_MC);
        end
        step("to_err", 0, 0, 0, 0, 0, 1, 0, V_ERR);
        step("to_err_done_ignored", 0, 0, 0, 0, 0, 0, 1, V_ERR);
        step("to_err_sticky", 1, 1, 5, 5, 5, 0, 0, V_ERR);
        pulse_reset("rst_from_err");
        step("err_cleared", 0, 0, 0, 0, 0, 0, 0, V_NORM);

        // Statistics: two load-use stalls and one flush since the last reset.
        step("st_lu1", 0, 1, 3, 3, 0, 0, 0, V_LU);
        step("st_gap", 0, 0, 0, 0, 0, 0, 0, V_NORM);
        step("st_lu2", 0, 1, 4, 0, 4, 0, 0, V_LU);
        step("st_br", 1, 0, 0, 0, 0, 0, 0, V_BR);
        step("st_end", 0, 0, 0, 0, 0, 0, 0, V_NORM);
        check("stall_cnt", stall_cnt, EXP_STALLS);
        check("flush_cnt", flush_cnt, EXP_FLUSHES);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
